// File: rtl/nor_decoder_sweep_ctrl.sv
// rtl/nor_decoder_sweep_ctrl.sv - truth-table sweep controller for the 2-input NOR-decoder block
`timescale 1ns/1ps
// Purpose: drives the four {r1,r0} vectors (0,1,2,3) into the NOR-decoder logic
// block. Each vector is held for SETTLE_CYC settle cycles plus one sample cycle.
// In the sample cycle out24/out25/out26 are compared against the expected truth
// table, and any mismatch is flagged per vector.
// Optional feature: define NOR_SWEEP_ERRLOG_EN to add a first-mismatch error log.
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   start_i, abort_i                   sweep request (IDLE only) / sweep cancel
//   out24_i, out25_i, out26_i          logic-block outputs under test
//   r1_drv_o, r0_drv_o                 registered drive of logic-block inputs
//   busy_o                             high while settling or sampling
//   done_o                             one-cycle pulse on sweep completion
//   pass_o                             all four vectors matched
//   fail_mask_o                        bit v set if vector v mismatched
//   err_valid_o, err_vec_o, err_obs_o  (errlog) first mismatching vector and
//                                      the {out24,out25,out26} observed for it
module nor_decoder_sweep_ctrl #(
  parameter int unsigned SETTLE_CYC = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       out24_i,
  input  logic       out25_i,
  input  logic       out26_i,
  output logic       r1_drv_o,
  output logic       r0_drv_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [3:0] fail_mask_o
`ifdef NOR_SWEEP_ERRLOG_EN
  ,
  output logic       err_valid_o,
  output logic [1:0] err_vec_o,
  output logic [2:0] err_obs_o
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

  localparam logic [15:0] CNT_RELOAD = 16'(SETTLE_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  // While busy the drive register doubles as the vector index.
  logic [1:0]  drv_q, drv_d;
  logic [3:0]  mask_q, mask_d;
  logic        pass_q, pass_d;
  logic [2:0]  obs;
  logic        accept;
  logic        mism;

  function automatic logic [2:0] expected(input logic [1:0] v);
    return {~(v[1] & v[0]), ~(~v[1] & v[0]), ~(v[1] & ~v[0])};
  endfunction

  assign obs    = {out24_i, out25_i, out26_i};
  assign accept = start_i & ~abort_i;
  assign mism   = (obs != expected(drv_q));

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (abort_i)             state_d = ST_IDLE;
        else if (cnt_q == 16'd0) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (abort_i)             state_d = ST_IDLE;
        else if (drv_q == 2'd3)  state_d = ST_DONE;
        else                     state_d = ST_SETTLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy_o = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    done_o = (state_q == ST_DONE);
  end

  // Datapath next values
  always_comb begin
    cnt_d  = cnt_q;
    drv_d  = drv_q;
    mask_d = mask_q;
    pass_d = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (abort_i) begin
          pass_d = 1'b0;
        end else if (start_i) begin
          cnt_d  = CNT_RELOAD;
          drv_d  = 2'd0;
          mask_d = 4'd0;
          pass_d = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (abort_i) begin
          drv_d  = 2'd0;
          pass_d = 1'b0;
        end else if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_SAMPLE: begin
        // An abort here discards this cycle's comparison.
        if (abort_i) begin
          drv_d  = 2'd0;
          pass_d = 1'b0;
        end else begin
          if (mism) mask_d[drv_q] = 1'b1;
          if (drv_q == 2'd3) begin
            drv_d  = 2'd0;
            pass_d = (mask_d == 4'd0);  // includes the bit set just above
          end else begin
            drv_d = drv_q + 2'd1;
            cnt_d = CNT_RELOAD;
          end
        end
      end
      default: drv_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= 16'd0;
      drv_q  <= 2'd0;
      mask_q <= 4'd0;
      pass_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      drv_q  <= drv_d;
      mask_q <= mask_d;
      pass_q <= pass_d;
    end
  end

  assign r1_drv_o    = drv_q[1];
  assign r0_drv_o    = drv_q[0];
  assign pass_o      = pass_q;
  assign fail_mask_o = mask_q;

`ifdef NOR_SWEEP_ERRLOG_EN
  logic       ev_q, ev_d;
  logic [1:0] evec_q, evec_d;
  logic [2:0] eobs_q, eobs_d;

  // Only the first mismatch of a sweep is kept.
  always_comb begin
    ev_d   = ev_q;
    evec_d = evec_q;
    eobs_d = eobs_q;
    if ((state_q == ST_IDLE) && accept) begin
      ev_d   = 1'b0;
      evec_d = 2'd0;
      eobs_d = 3'd0;
    end else if ((state_q == ST_SAMPLE) && !abort_i && mism && !ev_q) begin
      ev_d   = 1'b1;
      evec_d = drv_q;
      eobs_d = obs;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ev_q   <= 1'b0;
      evec_q <= 2'd0;
      eobs_q <= 3'd0;
    end else begin
      ev_q   <= ev_d;
      evec_q <= evec_d;
      eobs_q <= eobs_d;
    end
  end

  assign err_valid_o = ev_q;
  assign err_vec_o   = evec_q;
  assign err_obs_o   = eobs_q;
`endif

endmodule

// File: tb/tb_nor_decoder_sweep_ctrl.sv
// tb/tb_nor_decoder_sweep_ctrl.sv - self-checking bench for nor_decoder_sweep_ctrl
`timescale 1ns/1ps
module tb_nor_decoder_sweep_ctrl;

  localparam int SC = 8;
  localparam int NK = 4 * (SC + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, start1 = 1'b0, abort1 = 1'b0;
  logic stuck25 = 1'b0;

  logic out24, out25, out26, r1, r0, busy, done, pass;
  logic [3:0] fmask;
  logic o24_1, o25_1, o26_1, r1_1, r0_1, busy1, done1, pass1;
  logic [3:0] fmask1;
`ifdef NOR_SWEEP_ERRLOG_EN
  logic ev, ev1;
  logic [1:0] evec, evec1;
  logic [2:0] eobs, eobs1;
`endif

  always #5 clk = ~clk;

  // Logic block under test, with an optional stuck-at-1 fault on out25
  assign out24 = ~(r1 & r0);
  assign out25 = ~(~r1 & r0) | stuck25;
  assign out26 = ~(r1 & ~r0);
  assign o24_1 = ~(r1_1 & r0_1);
  assign o25_1 = ~(~r1_1 & r0_1);
  assign o26_1 = ~(r1_1 & ~r0_1);

  nor_decoder_sweep_ctrl #(.SETTLE_CYC(SC)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .out24_i(out24), .out25_i(out25), .out26_i(out26),
    .r1_drv_o(r1), .r0_drv_o(r0), .busy_o(busy), .done_o(done),
    .pass_o(pass), .fail_mask_o(fmask)
`ifdef NOR_SWEEP_ERRLOG_EN
    , .err_valid_o(ev), .err_vec_o(evec), .err_obs_o(eobs)
`endif
  );

  nor_decoder_sweep_ctrl #(.SETTLE_CYC(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .abort_i(abort1),
    .out24_i(o24_1), .out25_i(o25_1), .out26_i(o26_1),
    .r1_drv_o(r1_1), .r0_drv_o(r0_1), .busy_o(busy1), .done_o(done1),
    .pass_o(pass1), .fail_mask_o(fmask1)
`ifdef NOR_SWEEP_ERRLOG_EN
    , .err_valid_o(ev1), .err_vec_o(evec1), .err_obs_o(eobs1)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference table {out24,out25,out26} per vector
  function automatic logic [2:0] truth(input int v);
    case (v)
      0: return 3'b111;
      1: return 3'b101;
      2: return 3'b110;
      default: return 3'b011;
    endcase
  endfunction

  function automatic logic [2:0] seen(input int v);
    return truth(v) | (stuck25 ? 3'b010 : 3'b000);
  endfunction

  // Mismatch bit produced by sweep cycle k (k=0 is the first driven cycle)
  function automatic logic [3:0] hit_at(input int k);
    int v;
    v = k / (SC + 1);
    if ((k % (SC + 1)) == SC && seen(v) != truth(v)) return 4'(1 << v);
    return 4'd0;
  endfunction

  // Behavioural model: m_k counts cycles since the sweep was accepted
  logic       m_act = 1'b0;
  int         m_k = 0;
  logic [3:0] m_mask = 4'd0;
  logic       m_pass = 1'b0;
  logic       m_ev = 1'b0;
  logic [1:0] m_evec = 2'd0;
  logic [2:0] m_eobs = 3'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 1'b0; m_k <= 0; m_mask <= 4'd0; m_pass <= 1'b0;
      m_ev <= 1'b0; m_evec <= 2'd0; m_eobs <= 3'd0;
    end else if (m_act) begin
      if (m_k < NK) begin
        if (abort) begin
          m_act <= 1'b0; m_pass <= 1'b0;
        end else begin
          m_k <= m_k + 1;
          m_mask <= m_mask | hit_at(m_k);
          if (hit_at(m_k) != 4'd0 && !m_ev) begin
            m_ev <= 1'b1;
            m_evec <= 2'(m_k / (SC + 1));
            m_eobs <= seen(m_k / (SC + 1));
          end
          if (m_k == NK - 1) m_pass <= ((m_mask | hit_at(m_k)) == 4'd0);
        end
      end else begin
        m_act <= 1'b0;
      end
    end else begin
      if (abort) m_pass <= 1'b0;
      else if (start) begin
        m_act <= 1'b1; m_k <= 0; m_mask <= 4'd0; m_pass <= 1'b0;
        m_ev <= 1'b0; m_evec <= 2'd0; m_eobs <= 3'd0;
      end
    end
  end

  logic       e_busy, e_done;
  logic [1:0] e_drv;

  always @(negedge clk) begin
    e_busy = m_act && (m_k < NK);
    e_done = m_act && (m_k == NK);
    e_drv  = e_busy ? 2'(m_k / (SC + 1)) : 2'd0;
    check("m_busy", 32'(busy), 32'(e_busy));
    check("m_done", 32'(done), 32'(e_done));
    check("m_drv", 32'({r1, r0}), 32'(e_drv));
    check("m_pass", 32'(pass), 32'(m_pass));
    check("m_mask", 32'(fmask), 32'(m_mask));
`ifdef NOR_SWEEP_ERRLOG_EN
    check("m_err_valid", 32'(ev), 32'(m_ev));
    check("m_err_vec", 32'(evec), 32'(m_evec));
    check("m_err_obs", 32'(eobs), 32'(m_eobs));
`endif
  end

  // Per-edge traces; en = number of edges since start was raised
  int en = 0;
  int d8 = -1;
  int d1 = -1;
  logic [1:0] tr_drv [0:63];
  logic       tr_busy [0:63];
  logic       tr_done [0:63];
  logic       tr_pass [0:63];
  logic [3:0] tr_mask [0:63];
  logic [1:0] tr1_drv [0:63];
  logic       tr1_pass [0:63];

  task automatic adv();
    @(negedge clk);
    en++;
  endtask

  task automatic rec();
    tr_drv[en] = {r1, r0};
    tr_busy[en] = busy;
    tr_done[en] = done;
    tr_pass[en] = pass;
    tr_mask[en] = fmask;
    tr1_drv[en] = {r1_1, r0_1};
    tr1_pass[en] = pass1;
    if (done && d8 < 0) d8 = en;
    if (done1 && d1 < 0) d1 = en;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_drv", 32'({r1, r0}), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_mask", 32'(fmask), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // start together with abort in IDLE: nothing happens
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("sa_busy", 32'(busy), 32'd0);
    check("sa_drv", 32'({r1, r0}), 32'd0);
    @(negedge clk);

    // Clean sweep on both instances, plus a start pulse while busy
    d8 = -1; d1 = -1; start = 1'b1; start1 = 1'b1; en = 0;
    for (int i = 0; i < 45; i++) begin
      adv();
      if (en == 1) begin start = 1'b0; start1 = 1'b0; end
      if (en == 5) start = 1'b1;
      if (en == 6) start = 1'b0;
      rec();
    end
    check("b_done_edge", 32'(d8), 32'd37);
    check("b_drv1", 32'(tr_drv[1]), 32'd0);
    check("b_drv9", 32'(tr_drv[9]), 32'd0);
    check("b_drv10", 32'(tr_drv[10]), 32'd1);
    check("b_drv18", 32'(tr_drv[18]), 32'd1);
    check("b_drv19", 32'(tr_drv[19]), 32'd2);
    check("b_drv28", 32'(tr_drv[28]), 32'd3);
    check("b_drv36", 32'(tr_drv[36]), 32'd3);
    check("b_drv37", 32'(tr_drv[37]), 32'd0);
    check("b_busy1", 32'(tr_busy[1]), 32'd1);
    check("b_busy37", 32'(tr_busy[37]), 32'd0);
    check("b_done38", 32'(tr_done[38]), 32'd0);
    check("b_pass37", 32'(tr_pass[37]), 32'd1);
    check("b_mask37", 32'(tr_mask[37]), 32'd0);
    check("s1_done_edge", 32'(d1), 32'd9);
    check("s1_drv2", 32'(tr1_drv[2]), 32'd0);
    check("s1_drv3", 32'(tr1_drv[3]), 32'd1);
    check("s1_drv6", 32'(tr1_drv[6]), 32'd2);
    check("s1_drv8", 32'(tr1_drv[8]), 32'd3);
    check("s1_pass9", 32'(tr1_pass[9]), 32'd1);

    // out25 stuck at 1
    stuck25 = 1'b1; d8 = -1; start = 1'b1; en = 0;
    for (int i = 0; i < 40; i++) begin
      adv();
      if (en == 1) start = 1'b0;
      rec();
    end
    check("c_done_edge", 32'(d8), 32'd37);
    check("c_mask", 32'(fmask), 32'b0010);
    check("c_pass", 32'(pass), 32'd0);
`ifdef NOR_SWEEP_ERRLOG_EN
    check("c_err_valid", 32'(ev), 32'd1);
    check("c_err_vec", 32'(evec), 32'd1);
    check("c_err_obs", 32'(eobs), 32'b111);
`endif

    // Abort in SETTLE of vector 2 after a vector-1 mismatch
    d8 = -1; start = 1'b1; en = 0;
    for (int i = 0; i < 45; i++) begin
      adv();
      if (en == 1) start = 1'b0;
      if (en == 21) abort = 1'b1;
      if (en == 22) abort = 1'b0;
      rec();
    end
    check("d_drv21", 32'(tr_drv[21]), 32'd2);
    check("d_drv22", 32'(tr_drv[22]), 32'd0);
    check("d_busy22", 32'(tr_busy[22]), 32'd0);
    check("d_no_done", 32'(d8), 32'hffff_ffff);
    check("d_mask", 32'(fmask), 32'b0010);
    check("d_pass", 32'(pass), 32'd0);
    stuck25 = 1'b0; d8 = -1; start = 1'b1; en = 0;
    for (int i = 0; i < 40; i++) begin
      adv();
      if (en == 1) start = 1'b0;
      rec();
    end
    check("d2_mask1", 32'(tr_mask[1]), 32'd0);
    check("d2_done_edge", 32'(d8), 32'd37);
    check("d2_pass37", 32'(tr_pass[37]), 32'd1);

    // Asynchronous reset mid-sweep
    stuck25 = 1'b1; start = 1'b1; en = 0;
    for (int i = 0; i < 20; i++) begin
      adv();
      if (en == 1) start = 1'b0;
    end
    check("e_mask_pre", 32'(fmask), 32'b0010);
    check("e_busy_pre", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("e_rst_busy", 32'(busy), 32'd0);
    check("e_rst_done", 32'(done), 32'd0);
    check("e_rst_drv", 32'({r1, r0}), 32'd0);
    check("e_rst_mask", 32'(fmask), 32'd0);
    check("e_rst_pass", 32'(pass), 32'd0);
    @(negedge clk);
    rst = 1'b0; stuck25 = 1'b0;
    @(negedge clk);
    d8 = -1; start = 1'b1; en = 0;
    for (int i = 0; i < 40; i++) begin
      adv();
      if (en == 1) start = 1'b0;
      rec();
    end
    check("e_done_edge", 32'(d8), 32'd37);
    check("e_pass37", 32'(tr_pass[37]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nor_decoder_sweep_ctrl.md
# nor_decoder_sweep_ctrl

Controller that exercises the 2-input NOR-decoder logic block, which takes inputs `r1`, `r0` and produces outputs `out24`, `out25`, `out26`. On a start request it drives the four input combinations in order. After each one it waits a programmable settle time, because gate responses are slow relative to the clock. It then samples the three outputs and checks them against the expected truth table. The block sits between the test/config host and the logic block, and owns the `r1`/`r0` drive for the whole sweep.

## Interface
- `SETTLE_CYC`, default 8: cycles the block holds each vector before sampling. Legal range 1..65535.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin a sweep. Honoured only in IDLE.
- `abort` in 1: cancels a sweep in progress.
- `out24` in 1: logic-block output, synchronous to `clk`.
- `out25` in 1: logic-block output, synchronous to `clk`.
- `out26` in 1: logic-block output, synchronous to `clk`.
- `r1_drv` out 1: drives logic-block input `r1`. Registered.
- `r0_drv` out 1: drives logic-block input `r0`. Registered.
- `busy` out 1: high in SETTLE and SAMPLE.
- `done` out 1: one-cycle pulse when a sweep completes.
- `pass` out 1: set when all four vectors matched. Held until the next start, abort or reset.
- `fail_mask` out 4: bit v is set if vector v = {r1,r0} mismatched.

## Operation
- Expected outputs for vector {r1,r0}:
  - `out24 = ~(r1&r0)`
  - `out25 = ~(~r1&r0)`
  - `out26 = ~(r1&~r0)`
- Expected values per vector, as {out24,out25,out26}:
  - vector 0: 111
  - vector 1: 101
  - vector 2: 110
  - vector 3: 011
- Vectors are applied in the order 0, 1, 2, 3.
- State machine states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - Drives `r1_drv` = `r0_drv` = 0.
  - On `start` (with `abort` low): clear `fail_mask` and `pass`, load vector 0 onto `r1_drv`/`r0_drv`, load settle counter = `SETTLE_CYC`-1, go to SETTLE.
- SETTLE:
  - Decrement the counter each cycle.
  - When the counter is 0, go to SAMPLE.
  - Vector drive is held constant throughout.
- SAMPLE:
  - One cycle.
  - Compare the three outputs to the expected value; on mismatch set `fail_mask[v]`.
  - If v<3: drive vector v+1, reload the counter, go to SETTLE.
  - If v=3: go to DONE.
- DONE:
  - One cycle.
  - `done`=1, `pass` = (final `fail_mask`==0), including the bit set in the last SAMPLE.
  - Drive returns to 0, next state IDLE.
- Abort:
  - `abort` in SETTLE or SAMPLE: next state IDLE, drive 0, `pass`=0, `fail_mask` keeps the bits accumulated so far, no `done` pulse.
  - A comparison scheduled in the same cycle as `abort` is discarded.
- Simultaneous events:
  - `start` while busy or in DONE is ignored.
  - `start`+`abort` in IDLE: abort wins, block stays IDLE.
- Vector index is 2 bits and never wraps mid-sweep. DONE is reached exactly after v=3.

## Timing
- Reset values:
  - state IDLE
  - `r1_drv`=0, `r0_drv`=0
  - `busy`=0, `done`=0, `pass`=0
  - `fail_mask`=0000
  - counter 0
  - error-log outputs 0
- Reset asserted mid-sweep: all of the above take effect immediately (asynchronous). No `done` pulse.
- Let `start` be sampled at edge 0:
  - Vector 0 is driven from edge 1.
  - Each vector is driven for `SETTLE_CYC`+1 cycles (SETTLE plus SAMPLE).
  - Sampling happens in the last of those cycles.
- `done` is high in the cycle after edge 4·(`SETTLE_CYC`+1)+1. With the default of 8, that is edge 37.
- `busy` is high from edge 1 up to, but not including, the DONE cycle.
- `pass` and `fail_mask` are valid in the DONE cycle and stay stable afterwards.

## Configuration
- `NOR_SWEEP_ERRLOG_EN` defined:
  - Adds outputs `err_valid` (1 bit), `err_vec` (2 bits) and `err_obs` (3 bits, observed {out24,out25,out26}).
  - They capture the first mismatching vector of a sweep only; later mismatches do not overwrite it.
  - Cleared on an accepted start and on reset.
- `NOR_SWEEP_ERRLOG_EN` undefined: those ports and registers are absent. All other behaviour is identical.

## Test plan
- Correct model, `SETTLE_CYC`=8, pulse `start`:
  - Drive sequence is 00, 01, 10, 11, each held 9 cycles.
  - `done` at edge 37, `pass`=1, `fail_mask`=0000.
- `out25` stuck at 1:
  - `fail_mask`=0010, `pass`=0.
  - With the macro: `err_valid`=1, `err_vec`=01, `err_obs`=111.
- `abort` during SETTLE of vector 2, with a mismatch injected on vector 1:
  - Drive 00 next cycle, no `done`, `pass`=0, `fail_mask`=0010.
  - A following `start` clears `fail_mask`.
- `start` pulsed again during busy, and `start`+`abort` together in IDLE:
  - Both are ignored; sweep timing is unchanged.
- `rst` asserted at edge 20 of a sweep:
  - All outputs return to reset values asynchronously.
  - A new `start` after release runs a full 37-cycle sweep.
- `SETTLE_CYC`=1:
  - Each vector is held 2 cycles, `done` at edge 9, `pass`=1 on the correct model.
